// File: rtl/port_fe_pkg.sv
// Shared types and constants for the 0xFE-style ULA port front end.
package port_fe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_ACT = 2'd1,
    ST_RD_ACT = 2'd2
  } fe_state_e;

  localparam logic [7:0] PORT_MASK_DEF  = 8'h01;
  localparam logic [7:0] PORT_MATCH_DEF = 8'h00;

  localparam logic [3:0] DAC_W_SOUND    = 4'd8;
  localparam logic [3:0] DAC_W_TAPE_OUT = 4'd4;
  localparam logic [3:0] DAC_W_TAPE_IN  = 4'd2;

  // Bits 7 and 5 read back as 1, bits 4..0 are unpopulated keyboard rows.
  function automatic logic [7:0] read_word(input logic tape);
    return {1'b1, tape, 1'b1, 5'b11111};
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a
// selectable reset level so idle-high strobes come out of reset inactive.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/port_fe_io.sv
// I/O port front end: border/MIC/beeper write latch, EAR read with glitch filter.
// Optional PWM mix output on dac_out when PORT_FE_DAC_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for a decoded IORQ write or read
// ST_WR_ACT | write latched, waiting for strobes to release
// ST_RD_ACT | read data driven, waiting for strobes to release
module port_fe_io
  import port_fe_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]  PORT_MASK  = ADDR_W'(PORT_MASK_DEF),
  parameter logic [ADDR_W-1:0]  PORT_MATCH = ADDR_W'(PORT_MATCH_DEF),
  parameter int unsigned        FILT_LEN   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [7:0]        cpu_d,
  input  logic              iorq_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic              tape_in,
  output logic [2:0]        border,
  output logic              tape_out,
  output logic              sound,
  output logic [7:0]        rd_data,
  output logic              rd_oe,
  output logic              wr_stb
`ifdef PORT_FE_DAC_EN
  ,
  output logic              dac_out
`endif
);

  logic iorq_s, wr_s, rd_s, tape_s;
  logic hit;
  logic tape_filt;
  logic [7:0] filt_cnt;
  fe_state_e state;
  logic armed;
  logic [1:0] settle;
  logic unused_d_hi;

  sync2 #(.RST_VAL(1'b1)) u_sync_iorq (.clk(clk), .rst(rst), .d(iorq_n),  .q(iorq_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_wr   (.clk(clk), .rst(rst), .d(wr_n),    .q(wr_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_rd   (.clk(clk), .rst(rst), .d(rd_n),    .q(rd_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_tape (.clk(clk), .rst(rst), .d(tape_in), .q(tape_s));

  assign hit         = ((cpu_a & PORT_MASK) == (PORT_MATCH & PORT_MASK));
  assign unused_d_hi = ^cpu_d[7:5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tape_filt <= 1'b1;
      filt_cnt  <= '0;
    end else if (tape_s == tape_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == 8'(FILT_LEN - 1)) begin
      tape_filt <= tape_s;
      filt_cnt  <= '0;
    end else begin
      filt_cnt <= filt_cnt + 8'd1;
    end
  end

  // After reset the synchronisers show their forced-idle value for two
  // clocks; arming waits for a real idle sample so a cycle that straddled
  // reset release is not latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      border   <= '0;
      tape_out <= 1'b0;
      sound    <= 1'b0;
      wr_stb   <= 1'b0;
      rd_oe    <= 1'b0;
      rd_data  <= read_word(1'b1);
      armed    <= 1'b0;
      settle   <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (settle != 2'd2) settle <= settle + 2'd1;
      case (state)
        ST_IDLE: begin
          if (!armed) begin
            if (settle == 2'd2 && (iorq_s || (wr_s && rd_s))) armed <= 1'b1;
          end else if (!iorq_s && !wr_s && hit) begin
            state    <= ST_WR_ACT;
            border   <= cpu_d[2:0];
            tape_out <= cpu_d[3];
            sound    <= cpu_d[4];
            wr_stb   <= 1'b1;
          end else if (!iorq_s && !rd_s && hit) begin
            state   <= ST_RD_ACT;
            rd_oe   <= 1'b1;
            rd_data <= read_word(tape_filt);
          end
        end
        ST_WR_ACT: begin
          if (iorq_s || wr_s) state <= ST_IDLE;
        end
        ST_RD_ACT: begin
          if (iorq_s || rd_s) begin
            state <= ST_IDLE;
            rd_oe <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PORT_FE_DAC_EN
  logic [3:0] pwm_cnt;
  logic [3:0] dac_level;

  assign dac_level = (sound     ? DAC_W_SOUND    : 4'd0)
                   + (tape_out  ? DAC_W_TAPE_OUT : 4'd0)
                   + (tape_filt ? DAC_W_TAPE_IN  : 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      dac_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      dac_out <= (pwm_cnt < dac_level);
    end
  end
`endif

endmodule
